// File: rtl/uart_tx_sched_pkg.sv
// Shared constants and state type for the UART transmit scheduler.
package uart_tx_sched_pkg;

   // uart_mmio register map
   localparam logic [1:0] UART_ADDR_DATA = 2'b00;
   localparam logic [1:0] UART_ADDR_STAT = 2'b01;

   // STATUS register bit positions
   localparam int unsigned STAT_TX_BUSY = 0;
   localparam int unsigned STAT_RX_PEND = 1;

   // Drain FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POLL  = 2'd1,
      S_WRITE = 2'd2,
      S_GUARD = 2'd3
   } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// MMIO port between the scheduler (master) and uart_mmio (slave).
interface uart_tx_sched_if;
   import uart_tx_sched_pkg::*;

   logic        o_sel;
   logic        o_we;
   logic        o_re;
   logic [1:0]  o_addr;
   logic [15:0] o_wdata;
   logic [15:0] i_rdata;
   logic        i_rdy;

   modport master (
      output o_sel, o_we, o_re, o_addr, o_wdata,
      input  i_rdata, i_rdy
   );

   modport slave (
      input  o_sel, o_we, o_re, o_addr, o_wdata,
      output i_rdata, i_rdy
   );

endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// 8-bit synchronous FIFO with occupancy count and a synchronous flush.
module uart_tx_sched_sync_fifo
   import uart_tx_sched_pkg::*;
#(
   parameter int unsigned AW = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [7:0]    o_data,
   output logic [AW:0]   o_level,
   output logic          o_full,
   output logic          o_empty
);

   localparam int unsigned  DEPTH    = 2 ** AW;
   localparam logic [AW:0]  LVL_FULL = {1'b1, {AW{1'b0}}};

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_level == LVL_FULL);
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage, pointers and level; flush overrides any push/pop in the same cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte collector for NUM_REQ requesters feeding a FIFO that is
// drained into uart_mmio by polling STATUS and writing DATA.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned FIFO_AW      = 3,
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [8*NUM_REQ-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]     o_req_ready,
   input  logic                   i_flush,
   uart_tx_sched_if.master        mmio,
   output logic [FIFO_AW:0]       o_level,
   output logic                   o_idle,
   output logic [15:0]            o_sent_cnt
);

   localparam int unsigned RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned GW  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

   logic [RRW-1:0] r_rr;
   logic [RRW-1:0] w_grant;
   logic [RRW:0]   w_cand;
   logic           w_any;
   logic           w_accept;
   logic [7:0]     w_push_data;

   logic           w_full;
   logic           w_empty;
   logic           w_pop;
   logic [7:0]     w_head;

   sched_state_t   r_state;
   sched_state_t   w_state_nxt;
   logic [GW-1:0]  r_guard;
   logic [GW-1:0]  w_guard_nxt;
   logic [15:0]    r_sent_cnt;
   logic [15:0]    w_sent_nxt;
   logic           w_unused_rdata;

   assign w_unused_rdata = ^mmio.i_rdata[15:1];

   // Grant: first valid requester at or after the round-robin pointer
   always_comb begin
      w_grant = r_rr;
      w_any   = 1'b0;
      w_cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_cand = {1'b0, r_rr} + (RRW+1)'(i);
         if (w_cand >= (RRW+1)'(NUM_REQ)) begin
            w_cand = w_cand - (RRW+1)'(NUM_REQ);
         end
         if (!w_any && i_req_valid[w_cand[RRW-1:0]]) begin
            w_any   = 1'b1;
            w_grant = w_cand[RRW-1:0];
         end
      end
   end

   // One-hot ready for the granted requester and its byte for the FIFO
   always_comb begin
      o_req_ready = '0;
      w_push_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_grant == RRW'(k)) begin
            o_req_ready[k] = w_any & ~w_full & ~i_flush;
            w_push_data    = i_req_data[8*k +: 8];
         end
      end
   end

   assign w_accept = |o_req_ready;

   // Round-robin pointer moves past the requester that was just served
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr <= '0;
      end else if (w_accept) begin
         r_rr <= (w_grant == RRW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
      end
   end

   uart_tx_sched_sync_fifo #(
      .AW (FIFO_AW)
   ) u_sync_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_accept),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (i_flush),
      .o_data  (w_head),
      .o_level (o_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM state, guard timer and sent counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_guard    <= '0;
         r_sent_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_guard    <= w_guard_nxt;
         r_sent_cnt <= w_sent_nxt;
      end
   end

   // Next state and MMIO strobes; bus signals depend on state only, so a
   // stalled write holds them unchanged until rdy
   always_comb begin
      w_state_nxt  = r_state;
      w_guard_nxt  = r_guard;
      w_sent_nxt   = r_sent_cnt;
      w_pop        = 1'b0;
      mmio.o_sel   = 1'b0;
      mmio.o_we    = 1'b0;
      mmio.o_re    = 1'b0;
      mmio.o_addr  = UART_ADDR_DATA;
      mmio.o_wdata = '0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) w_state_nxt = S_POLL;
         end
         S_POLL: begin
            mmio.o_sel  = 1'b1;
            mmio.o_re   = 1'b1;
            mmio.o_addr = UART_ADDR_STAT;
            if (mmio.i_rdy && !mmio.i_rdata[STAT_TX_BUSY]) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            mmio.o_sel   = 1'b1;
            mmio.o_we    = 1'b1;
            mmio.o_addr  = UART_ADDR_DATA;
            mmio.o_wdata = {8'h00, w_head};
            if (mmio.i_rdy) begin
               w_pop       = 1'b1;
               w_sent_nxt  = r_sent_cnt + 16'd1;
               w_guard_nxt = GW'(GUARD_CYCLES - 1);
               w_state_nxt = S_GUARD;
            end
         end
         S_GUARD: begin
            if (r_guard == '0) begin
               w_state_nxt = w_empty ? S_IDLE : S_POLL;
            end else begin
               w_guard_nxt = r_guard - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A write completing in the flush cycle keeps its count; only the state is forced
      if (i_flush) w_state_nxt = S_IDLE;
   end

   assign o_idle     = w_empty & (r_state == S_IDLE);
   assign o_sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a random
// phase, scored against a queue-based model of arbitration and FIFO order.
module tb_uart_tx_sched;

   localparam int NREQ  = 2;
   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [8*NREQ-1:0] req_data  = '0;
   logic [NREQ-1:0]   req_ready;
   logic              flush = 1'b0;
   logic [3:0]        level;
   logic              idle;
   logic [15:0]       sent;

   uart_tx_sched_if bus ();

   uart_tx_sched #(
      .NUM_REQ      (NREQ),
      .FIFO_AW      (3),
      .GUARD_CYCLES (2)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .i_flush     (flush),
      .mmio        (bus),
      .o_level     (level),
      .o_idle      (idle),
      .o_sent_cnt  (sent)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [7:0]      m_q[$];
   int              m_rr;
   logic [15:0]     m_sent;
   int              busy_cnt;
   int              busy_mode;   // 0 = UART frame model, 1 = forced busy, 2 = forced free
   int              rdy_mode;    // 0 = random, 1 = always ready, 2 = never ready
   bit              auto_data;
   bit              cur_busy;
   bit              poll_ok;
   int              cyc_n = 0;
   int              first_poll_cyc;
   int              last_write_cyc;
   int              n_reads;
   int              n_writes;
   int              acc_log[$];
   logic [NREQ-1:0] obs_ready;
   logic [15:0]     last_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive the slave, check this cycle's outputs, update the model.
   task automatic cycle();
      int              g;
      int              acc;
      bit              wr;
      logic [NREQ-1:0] exp_rdy;
      logic [31:0]     exp_w;
      if (busy_mode == 1)      cur_busy = 1'b1;
      else if (busy_mode == 2) cur_busy = 1'b0;
      else                     cur_busy = (busy_cnt > 0);
      bus.i_rdata = {14'($urandom), 1'($urandom), cur_busy};
      bus.i_rdy   = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
         if (g < 0 && req_valid[(m_rr + i) % NREQ]) g = (m_rr + i) % NREQ;
      end
      exp_rdy = '0;
      if (g >= 0 && !flush && m_q.size() < DEPTH) exp_rdy[g] = 1'b1;
      obs_ready = req_ready;
      chk("req_ready", req_ready, exp_rdy);
      chk("level", level, m_q.size());
      chk("sent_cnt", sent, m_sent);
      chk("re_we_exclusive", bus.o_re & bus.o_we, 0);
      chk("strobe_without_sel", (bus.o_re | bus.o_we) & ~bus.o_sel, 0);
      if (bus.o_sel && bus.o_re) begin
         n_reads++;
         if (first_poll_cyc < 0) first_poll_cyc = cyc_n;
         chk("poll_addr", bus.o_addr, 1);
         if (bus.i_rdy && !cur_busy) poll_ok = 1'b1;
      end
      if (bus.o_sel && bus.o_we) chk("write_addr", bus.o_addr, 0);
      wr = bus.o_sel && bus.o_we && bus.i_rdy;
      if (wr) begin
         chk("poll_before_write", poll_ok, 1);
         poll_ok = 1'b0;
         exp_w = (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'hDEAD0000;
         chk("wdata", bus.o_wdata, exp_w);
         last_wdata     = bus.o_wdata;
         last_write_cyc = cyc_n;
         n_writes++;
         m_sent++;
         busy_cnt = $urandom_range(2, 10);
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      acc = -1;
      if (flush) begin
         m_q.delete();
         poll_ok = 1'b0;
      end else begin
         if (wr && m_q.size() > 0) void'(m_q.pop_front());
         if (exp_rdy != '0) begin
            m_q.push_back(req_data[8*g +: 8]);
            m_rr = (g + 1) % NREQ;
            acc_log.push_back(g);
            acc = g;
         end
      end
      @(negedge clk);
      cyc_n++;
      if (auto_data && acc >= 0) req_data[8*acc +: 8] = 8'($urandom);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      req_valid   = '0;
      flush       = 1'b0;
      bus.i_rdy   = 1'b0;
      bus.i_rdata = '0;
      #1;
      chk("rst_sel", bus.o_sel, 0);
      chk("rst_we", bus.o_we, 0);
      chk("rst_re", bus.o_re, 0);
      chk("rst_addr", bus.o_addr, 0);
      chk("rst_wdata", bus.o_wdata, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_level", level, 0);
      chk("rst_idle", idle, 1);
      chk("rst_sent", sent, 0);
      m_q.delete();
      acc_log.delete();
      m_rr           = 0;
      m_sent         = '0;
      poll_ok        = 1'b0;
      busy_cnt       = 0;
      first_poll_cyc = -1;
      @(negedge clk);
      cyc_n++;
      rst = 1'b0;
   endtask

   initial begin
      int t0;
      int r0;
      int w0;
      int rel;
      int s0;
      int lvl0;
      busy_mode = 2;
      rdy_mode  = 1;
      auto_data = 1'b0;
      n_reads   = 0;
      n_writes  = 0;

      // T1: single byte 0x41 from req0
      do_reset();
      req_data[7:0] = 8'h41;
      req_valid     = 2'b01;
      t0 = cyc_n;
      cycle();
      chk("t1_ready0_same_cycle", obs_ready, 2'b01);
      req_valid = '0;
      w0 = n_writes;
      for (int k = 0; k < 40 && n_writes == w0; k++) cycle();
      chk("t1_write_seen", n_writes - w0, 1);
      chk("t1_first_poll_cycle", first_poll_cyc, t0 + 2);
      chk("t1_write_cycle", last_write_cyc, t0 + 3);
      chk("t1_wdata", last_wdata, 16'h0041);
      repeat (4) cycle();
      chk("t1_sent", sent, 1);
      chk("t1_idle", idle, 1);

      // T2: busy held for 10 polls, then released
      busy_mode = 1;
      req_data[15:8] = 8'($urandom);
      req_valid = 2'b10;
      cycle();
      req_valid = '0;
      r0 = n_reads;
      w0 = n_writes;
      for (int k = 0; k < 10 && n_reads == r0; k++) cycle();
      repeat (9) cycle();
      chk("t2_reads_while_busy", n_reads - r0, 10);
      chk("t2_no_write_while_busy", n_writes - w0, 0);
      busy_mode = 2;
      rel = cyc_n;
      cycle();
      cycle();
      chk("t2_write_after_release", last_write_cyc, rel + 1);
      chk("t2_write_count", n_writes - w0, 1);

      // T3: both requesters valid, round-robin order
      do_reset();
      busy_mode = 1;
      auto_data = 1'b1;
      req_data  = 16'($urandom);
      req_valid = 2'b11;
      repeat (4) cycle();
      req_valid = '0;
      chk("t3_accept_count", acc_log.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_accept_%0d", i), acc_log[i], i % 2);
      busy_mode = 2;
      w0 = n_writes;
      for (int k = 0; k < 200 && n_writes - w0 < 4; k++) cycle();
      chk("t3_all_written", n_writes - w0, 4);

      // T4: fill to full, then a pop and a push in the same cycle
      do_reset();
      busy_mode = 1;
      req_valid = 2'b11;
      repeat (8) cycle();
      chk("t4_level_full", level, 8);
      cycle();
      chk("t4_ready_when_full", obs_ready, 0);
      req_valid = '0;
      busy_mode = 2;
      cycle();
      busy_mode = 1;
      cycle();
      chk("t4_level_after_pop", level, 7);
      repeat (3) cycle();
      busy_mode = 2;
      cycle();
      lvl0 = level;
      req_valid = 2'b01;
      cycle();
      req_valid = '0;
      chk("t4_pushpop_write", last_write_cyc, cyc_n - 1);
      chk("t4_pushpop_ready", obs_ready, 2'b01);
      chk("t4_pushpop_level", level, lvl0);
      for (int k = 0; k < 300 && !idle; k++) cycle();
      chk("t4_drained_idle", idle, 1);

      // T5: flush with 5 bytes queued while polling
      do_reset();
      busy_mode = 1;
      req_valid = 2'b11;
      repeat (5) cycle();
      req_valid = '0;
      cycle();
      chk("t5_polling", bus.o_re, 1);
      chk("t5_level_before", level, 5);
      s0 = sent;
      flush     = 1'b1;
      req_valid = 2'b11;
      cycle();
      chk("t5_ready_in_flush", obs_ready, 0);
      flush     = 1'b0;
      req_valid = '0;
      chk("t5_level_after", level, 0);
      chk("t5_idle_after", idle, 1);
      chk("t5_sel_after", bus.o_sel, 0);
      chk("t5_re_after", bus.o_re, 0);
      chk("t5_we_after", bus.o_we, 0);
      chk("t5_sent_unchanged", sent, s0);
      auto_data = 1'b0;

      // T6: reset during a stalled write, then counter wrap
      do_reset();
      busy_mode = 2;
      rdy_mode  = 1;
      req_data[7:0] = 8'($urandom);
      req_valid = 2'b01;
      cycle();
      req_valid = '0;
      cycle();
      cycle();
      rdy_mode  = 2;
      bus.i_rdy = 1'b0;
      #1;
      chk("t6_write_active", bus.o_sel & bus.o_we, 1);
      rst = 1'b1;
      #1;
      chk("t6_sel_drop", bus.o_sel, 0);
      chk("t6_we_drop", bus.o_we, 0);
      rdy_mode = 1;
      do_reset();
      force dut.r_sent_cnt = 16'hFFFF;
      #1;
      release dut.r_sent_cnt;
      m_sent = 16'hFFFF;
      chk("t6_preload", sent, 16'hFFFF);
      req_data[7:0] = 8'($urandom);
      req_valid = 2'b01;
      cycle();
      req_valid = '0;
      w0 = n_writes;
      for (int k = 0; k < 40 && n_writes == w0; k++) cycle();
      cycle();
      chk("t6_wrap", sent, 0);

      // Random traffic against the frame-timed UART model
      do_reset();
      busy_mode = 0;
      rdy_mode  = 0;
      auto_data = 1'b1;
      req_data  = 16'($urandom);
      for (int n = 0; n < 2000; n++) begin
         req_valid = NREQ'($urandom);
         flush     = ($urandom_range(0, 99) == 0);
         cycle();
      end
      req_valid = '0;
      flush     = 1'b0;
      for (int k = 0; k < 500 && !idle; k++) cycle();
      chk("rnd_drained_idle", idle, 1);
      chk("rnd_level_zero", level, 0);
      chk("rnd_sent_total", sent, m_sent);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
